down_counter_seq: RTL and testbench

Loadable down-counting sequencer with a start/busy/done handshake. It is the consuming-end companion to the free-running 4-bit up counter in the ANN datapath. A controller loads a count, such as the remaining MAC cycles or weight indices for a neuron. The block steps that count down to zero and signals completion, either once or periodically in auto-reload mode. All outputs are registered.

---
 rtl/down_counter_seq.sv | 93 +++++++++
 tb/tb_down_counter_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/down_counter_seq.sv
// Loadable down-counter sequencer: start loads a count, steps to zero, then pulses done (or reloads in auto mode).
// Outputs register one edge after the controlling input; hold freezes a run, abort returns to idle on the next edge.
module down_counter_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] c_out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic             mode_reg;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= IDLE;
            c_out      <= '0;
            busy       <= 1'b0;
            tc         <= 1'b0;
            done       <= 1'b0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            c_out <= '0;
            busy  <= 1'b0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts start exactly like IDLE so runs can chain back to back
                    done <= 1'b0;
                    if (start) begin
                        state      <= RUN;
                        c_out      <= load_val;
                        reload_reg <= load_val;
                        mode_reg   <= auto_reload;
                        busy       <= 1'b1;
                        tc         <= (load_val == '0);
                    end else begin
                        state <= IDLE;
                        c_out <= '0;
                        busy  <= 1'b0;
                        tc    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (c_out > WIDTH'(1)) begin
                            c_out <= c_out - WIDTH'(1);
                            tc    <= 1'b0;
                        end else if (c_out == WIDTH'(1)) begin
                            c_out <= '0;
                            tc    <= 1'b1;
                        end else if (mode_reg) begin
                            c_out <= reload_reg;
                            tc    <= (reload_reg == '0);
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            tc    <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    c_out <= '0;
                    busy  <= 1'b0;
                    tc    <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_seq.sv
// Directed vector bench for down_counter_seq: table of per-edge inputs and expected outputs, plus an async reset sequence.
module tb_down_counter_seq;

    logic       clk;
    logic       res;
    logic       start;
    logic [3:0] load_val;
    logic       auto_reload;
    logic       hold;
    logic       abort;
    logic [3:0] c_out;
    logic       busy;
    logic       tc;
    logic       done;

    int n_cmp;
    int n_bad;

    down_counter_seq #(.WIDTH(4)) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .load_val   (load_val),
        .auto_reload(auto_reload),
        .hold       (hold),
        .abort      (abort),
        .c_out      (c_out),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       start;
        logic [3:0] load_val;
        logic       auto_reload;
        logic       hold;
        logic       abort;
        logic [3:0] e_cout;
        logic       e_busy;
        logic       e_tc;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] e_c, input logic e_b,
                         input logic e_t, input logic e_d);
        n_cmp++;
        if ({c_out, busy, tc, done} !== {e_c, e_b, e_t, e_d}) begin
            n_bad++;
            $display("FAIL %s: got c_out=%0d busy=%b tc=%b done=%b, want c_out=%0d busy=%b tc=%b done=%b",
                     name, c_out, busy, tc, done, e_c, e_b, e_t, e_d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input logic s, input logic [3:0] lv, input logic ar,
                       input logic h, input logic ab, input logic [3:0] ec, input logic eb,
                       input logic et, input logic ed);
        vec_t v;
        v.name = n; v.start = s; v.load_val = lv; v.auto_reload = ar; v.hold = h; v.abort = ab;
        v.e_cout = ec; v.e_busy = eb; v.e_tc = et; v.e_done = ed;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        res = 1'b0; start = 1'b0; load_val = 4'd0; auto_reload = 1'b0; hold = 1'b0; abort = 1'b0;

        //   name          st  ld    ar  hd  ab   c_out bsy tc  dn
        // one-shot L=3
        add("os_start",    1, 4'd3, 0, 0, 0,  4'd3, 1, 0, 0);
        add("os_2",        0, 4'd0, 0, 0, 0,  4'd2, 1, 0, 0);
        add("os_1",        0, 4'd0, 0, 0, 0,  4'd1, 1, 0, 0);
        add("os_0",        0, 4'd0, 0, 0, 0,  4'd0, 1, 1, 0);
        add("os_done",     0, 4'd0, 0, 0, 0,  4'd0, 0, 0, 1);
        add("os_idle",     0, 4'd0, 0, 0, 0,  4'd0, 0, 0, 0);
        // zero load, then back-to-back start during done
        add("z_start",     1, 4'd0, 0, 0, 0,  4'd0, 1, 1, 0);
        add("z_done",      0, 4'd0, 0, 0, 0,  4'd0, 0, 0, 1);
        add("b2b_start",   1, 4'd2, 0, 0, 0,  4'd2, 1, 0, 0);
        add("b2b_1",       0, 4'd0, 0, 0, 0,  4'd1, 1, 0, 0);
        add("b2b_0",       0, 4'd0, 0, 0, 0,  4'd0, 1, 1, 0);
        add("b2b_done",    0, 4'd0, 0, 0, 0,  4'd0, 0, 0, 1);
        add("b2b_idle",    0, 4'd0, 0, 0, 0,  4'd0, 0, 0, 0);
        // auto-reload L=2, inputs changed after acceptance
        add("ar_start",    1, 4'd2, 1, 0, 0,  4'd2, 1, 0, 0);
        add("ar_1",        0, 4'd7, 0, 0, 0,  4'd1, 1, 0, 0);
        add("ar_0",        0, 4'd7, 0, 0, 0,  4'd0, 1, 1, 0);
        add("ar_rl2",      0, 4'd7, 0, 0, 0,  4'd2, 1, 0, 0);
        add("ar_rl1",      0, 4'd7, 0, 0, 0,  4'd1, 1, 0, 0);
        add("ar_rl0",      0, 4'd7, 0, 0, 0,  4'd0, 1, 1, 0);
        add("ar_rl2b",     0, 4'd7, 0, 0, 0,  4'd2, 1, 0, 0);
        add("ar_abort",    0, 4'd7, 0, 0, 1,  4'd0, 0, 0, 0);
        add("ar_idle",     0, 4'd7, 0, 0, 0,  4'd0, 0, 0, 0);
        // auto-reload L=0: tc every cycle
        add("ar0_start",   1, 4'd0, 1, 0, 0,  4'd0, 1, 1, 0);
        add("ar0_a",       0, 4'd0, 0, 0, 0,  4'd0, 1, 1, 0);
        add("ar0_b",       0, 4'd0, 0, 0, 0,  4'd0, 1, 1, 0);
        add("ar0_abort",   0, 4'd0, 0, 0, 1,  4'd0, 0, 0, 0);
        // hold at c_out=2 for 3 cycles and at c_out=0 for 2 cycles
        add("h_start",     1, 4'd4, 0, 0, 0,  4'd4, 1, 0, 0);
        add("h_3",         0, 4'd0, 0, 0, 0,  4'd3, 1, 0, 0);
        add("h_2",         0, 4'd0, 0, 0, 0,  4'd2, 1, 0, 0);
        add("h_frz2a",     0, 4'd0, 0, 1, 0,  4'd2, 1, 0, 0);
        add("h_frz2b",     0, 4'd0, 0, 1, 0,  4'd2, 1, 0, 0);
        add("h_frz2c",     0, 4'd0, 0, 1, 0,  4'd2, 1, 0, 0);
        add("h_1",         0, 4'd0, 0, 0, 0,  4'd1, 1, 0, 0);
        add("h_0",         0, 4'd0, 0, 0, 0,  4'd0, 1, 1, 0);
        add("h_frz0a",     0, 4'd0, 0, 1, 0,  4'd0, 1, 1, 0);
        add("h_frz0b",     0, 4'd0, 0, 1, 0,  4'd0, 1, 1, 0);
        add("h_done",      0, 4'd0, 0, 0, 0,  4'd0, 0, 0, 1);
        add("h_idle",      0, 4'd0, 0, 0, 0,  4'd0, 0, 0, 0);
        // start during run ignored
        add("c_start",     1, 4'd5, 0, 0, 0,  4'd5, 1, 0, 0);
        add("c_4",         0, 4'd0, 0, 0, 0,  4'd4, 1, 0, 0);
        add("c_3",         0, 4'd0, 0, 0, 0,  4'd3, 1, 0, 0);
        add("c_ign9",      1, 4'd9, 0, 0, 0,  4'd2, 1, 0, 0);
        add("c_1",         0, 4'd0, 0, 0, 0,  4'd1, 1, 0, 0);
        add("c_0",         0, 4'd0, 0, 0, 0,  4'd0, 1, 1, 0);
        add("c_done",      0, 4'd0, 0, 0, 0,  4'd0, 0, 0, 1);
        add("c_idle",      0, 4'd0, 0, 0, 0,  4'd0, 0, 0, 0);
        // abort beats start in idle; abort beats hold in run
        add("abst_idle",   1, 4'd6, 0, 0, 1,  4'd0, 0, 0, 0);
        add("abst_after",  0, 4'd6, 0, 0, 0,  4'd0, 0, 0, 0);
        add("ah_start",    1, 4'd3, 0, 0, 0,  4'd3, 1, 0, 0);
        add("ah_abort",    0, 4'd3, 0, 1, 1,  4'd0, 0, 0, 0);
        add("ah_idle",     0, 4'd3, 0, 0, 0,  4'd0, 0, 0, 0);

        #12;
        check("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        res = 1'b1;
        step();
        check("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            start       = vecs[i].start;
            load_val    = vecs[i].load_val;
            auto_reload = vecs[i].auto_reload;
            hold        = vecs[i].hold;
            abort       = vecs[i].abort;
            step();
            check(vecs[i].name, vecs[i].e_cout, vecs[i].e_busy, vecs[i].e_tc, vecs[i].e_done);
        end

        // async reset mid-count at c_out=5, no clock edge involved
        start = 1'b1; load_val = 4'd7; auto_reload = 1'b0; hold = 1'b0; abort = 1'b0;
        step();
        start = 1'b0;
        check("rst_seq_7", 4'd7, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check("rst_seq_5", 4'd5, 1'b1, 1'b0, 1'b0);
        #2;
        res = 1'b0;
        #1;
        check("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("rst_held", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        res = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_release_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
